fmul: RTL and testbench

//  Pipelined IEEE-754 single-precision multiplier, y = x1 * x2.

---
 rtl/fmul.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_fmul.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fmul.sv
`default_nettype none
// ============================================================================
//  Module   : fmul
//  Purpose  : Pipelined IEEE-754 binary32 multiplier, y = x1 * x2.
//             Fully pipelined responder of the FPU en/done/busy handshake:
//             one operand pair accepted per cycle, result NSTAGE cycles later.
//             Denormal inputs are flushed to zero, denormal results flush to
//             signed zero, rounding is round-to-nearest-even.
//  Ports    : clk        clock, all state on posedge
//             rstn       asynchronous reset, active-high (1 = reset)
//             en         operand valid, x1/x2 sampled when en=1
//             x1, x2     binary32 operands
//             y          product, valid while done=1, held until next done
//             done       one-cycle pulse per accepted en, NSTAGE cycles later
//             busy       1 while any stage holds a valid operation
//             flags      {invalid, overflow, underflow}, FMUL_FLAGS_EN only
//  Params   : NSTAGE     latency en->done, legal 3..8; stages past 3 are delays
//  Config   : `define FMUL_FLAGS_EN adds the flags port and its logic.
//  Revision : 1.0  initial release
// ============================================================================
module fmul #(
    parameter int NSTAGE = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        en,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y,
    output logic        done,
    output logic        busy
`ifdef FMUL_FLAGS_EN
    ,
    output logic [2:0]  flags
`endif
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // ------------------------------------------------------------------
    // Stage 1: unpack and classify
    // ------------------------------------------------------------------
    logic        sign_a, sign_b;
    logic [7:0]  exp_a, exp_b;
    logic [22:0] frac_a, frac_b;
    logic        zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic        sp_nan, sp_inf, sp_zero;
    logic signed [9:0] exp_sum;

    assign {sign_a, exp_a, frac_a} = x1;
    assign {sign_b, exp_b, frac_b} = x2;

    // exponent field 0 covers both true zero and denormals (flushed)
    assign zero_a = (exp_a == 8'h00);
    assign zero_b = (exp_b == 8'h00);
    assign inf_a  = (exp_a == 8'hFF) && (frac_a == 23'd0);
    assign inf_b  = (exp_b == 8'hFF) && (frac_b == 23'd0);
    assign nan_a  = (exp_a == 8'hFF) && (frac_a != 23'd0);
    assign nan_b  = (exp_b == 8'hFF) && (frac_b != 23'd0);

    // Priority is resolved here so later stages see one-hot special codes
    assign sp_nan  = nan_a | nan_b | (inf_a & zero_b) | (inf_b & zero_a);
    assign sp_inf  = ~sp_nan & (inf_a | inf_b);
    assign sp_zero = ~sp_nan & ~sp_inf & (zero_a | zero_b);

    assign exp_sum = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - 10'sd127;

`ifdef FMUL_FLAGS_EN
    logic invalid_in;
    // a quiet NaN has fraction MSB set; anything else with a payload signals
    assign invalid_in = (inf_a & zero_b) | (inf_b & zero_a)
                      | (nan_a & ~frac_a[22]) | (nan_b & ~frac_b[22]);
`endif

    logic               v1, s1_sign, s1_nan, s1_inf, s1_zero;
    logic signed [9:0]  s1_exp;
    logic [23:0]        s1_ma, s1_mb;
`ifdef FMUL_FLAGS_EN
    logic               s1_inv;
`endif

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            v1      <= 1'b0;
            s1_sign <= 1'b0;
            s1_nan  <= 1'b0;
            s1_inf  <= 1'b0;
            s1_zero <= 1'b0;
            s1_exp  <= '0;
            s1_ma   <= '0;
            s1_mb   <= '0;
`ifdef FMUL_FLAGS_EN
            s1_inv  <= 1'b0;
`endif
        end else begin
            v1 <= en;
            if (en) begin
                s1_sign <= sign_a ^ sign_b;
                s1_nan  <= sp_nan;
                s1_inf  <= sp_inf;
                s1_zero <= sp_zero;
                s1_exp  <= exp_sum;
                s1_ma   <= {1'b1, frac_a};
                s1_mb   <= {1'b1, frac_b};
`ifdef FMUL_FLAGS_EN
                s1_inv  <= invalid_in;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: 24x24 mantissa product
    // ------------------------------------------------------------------
    logic               v2, s2_sign, s2_nan, s2_inf, s2_zero;
    logic signed [9:0]  s2_exp;
    logic [47:0]        s2_prod;
`ifdef FMUL_FLAGS_EN
    logic               s2_inv;
`endif

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            v2      <= 1'b0;
            s2_sign <= 1'b0;
            s2_nan  <= 1'b0;
            s2_inf  <= 1'b0;
            s2_zero <= 1'b0;
            s2_exp  <= '0;
            s2_prod <= '0;
`ifdef FMUL_FLAGS_EN
            s2_inv  <= 1'b0;
`endif
        end else begin
            v2 <= v1;
            if (v1) begin
                s2_sign <= s1_sign;
                s2_nan  <= s1_nan;
                s2_inf  <= s1_inf;
                s2_zero <= s1_zero;
                s2_exp  <= s1_exp;
                s2_prod <= s1_ma * s1_mb;
`ifdef FMUL_FLAGS_EN
                s2_inv  <= s1_inv;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: normalise, round (RNE), renormalise, pack
    // ------------------------------------------------------------------
    logic [23:0]        norm_m;
    logic               guard, sticky, round_up;
    logic signed [9:0]  norm_e, fin_e;
    logic [24:0]        rnd_m;
    logic [22:0]        fin_frac;
    logic [31:0]        result;
    logic               ovf, unf;

    always_comb begin
        // product of two [1,2) mantissas lies in [1,4): at most one shift
        if (s2_prod[47]) begin
            norm_m = s2_prod[47:24];
            guard  = s2_prod[23];
            sticky = |s2_prod[22:0];
            norm_e = s2_exp + 10'sd1;
        end else begin
            norm_m = s2_prod[46:23];
            guard  = s2_prod[22];
            sticky = |s2_prod[21:0];
            norm_e = s2_exp;
        end
        round_up = guard & (sticky | norm_m[0]);
        rnd_m    = {1'b0, norm_m} + {24'd0, round_up};
        // carry-out only happens from all-ones, leaving a zero fraction
        if (rnd_m[24]) begin
            fin_frac = rnd_m[23:1];
            fin_e    = norm_e + 10'sd1;
        end else begin
            fin_frac = rnd_m[22:0];
            fin_e    = norm_e;
        end

        ovf = 1'b0;
        unf = 1'b0;
        if (s2_nan) begin
            result = QNAN;
        end else if (s2_inf) begin
            result = {s2_sign, 8'hFF, 23'd0};
        end else if (s2_zero) begin
            result = {s2_sign, 31'd0};
        end else if (fin_e >= 10'sd255) begin
            result = {s2_sign, 8'hFF, 23'd0};
            ovf    = 1'b1;
        end else if (fin_e <= 10'sd0) begin
            result = {s2_sign, 31'd0};
            unf    = 1'b1;
        end else begin
            result = {s2_sign, fin_e[7:0], fin_frac};
        end
    end

    logic        v3;
    logic [31:0] y3;
`ifdef FMUL_FLAGS_EN
    logic [2:0]  fl3;
`endif

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            v3  <= 1'b0;
            y3  <= '0;
`ifdef FMUL_FLAGS_EN
            fl3 <= '0;
`endif
        end else begin
            v3 <= v2;
            if (v2) begin
                y3  <= result;
`ifdef FMUL_FLAGS_EN
                fl3 <= {s2_inv, ovf, unf};
`endif
            end
        end
    end

`ifndef FMUL_FLAGS_EN
    // overflow/underflow only feed the flags port
    logic unused_ok;
    assign unused_ok = ovf ^ unf;
`endif

    // ------------------------------------------------------------------
    // Stages 4..NSTAGE: pure delay; data only loads with a valid op so the
    // output naturally holds between done pulses
    // ------------------------------------------------------------------
    generate
        if (NSTAGE > 3) begin : g_delay
            logic [NSTAGE-4:0] dv;
            logic [31:0]       dy [NSTAGE-3];
`ifdef FMUL_FLAGS_EN
            logic [2:0]        dfl [NSTAGE-3];
`endif
            always_ff @(posedge clk or posedge rstn) begin
                if (rstn) begin
                    dv <= '0;
                    for (int i = 0; i < NSTAGE - 3; i++) begin
                        dy[i] <= '0;
`ifdef FMUL_FLAGS_EN
                        dfl[i] <= '0;
`endif
                    end
                end else begin
                    dv[0] <= v3;
                    if (v3) begin
                        dy[0] <= y3;
`ifdef FMUL_FLAGS_EN
                        dfl[0] <= fl3;
`endif
                    end
                    for (int i = 1; i < NSTAGE - 3; i++) begin
                        dv[i] <= dv[i-1];
                        if (dv[i-1]) begin
                            dy[i] <= dy[i-1];
`ifdef FMUL_FLAGS_EN
                            dfl[i] <= dfl[i-1];
`endif
                        end
                    end
                end
            end
            assign done = dv[NSTAGE-4];
            assign y    = dy[NSTAGE-4];
            assign busy = v1 | v2 | v3 | (|dv);
`ifdef FMUL_FLAGS_EN
            assign flags = dfl[NSTAGE-4];
`endif
        end else begin : g_nodelay
            assign done = v3;
            assign y    = y3;
            assign busy = v1 | v2 | v3;
`ifdef FMUL_FLAGS_EN
            assign flags = fl3;
`endif
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fmul.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_fmul
//  Purpose  : Directed self-checking bench for fmul (latency, rounding,
//             specials, back-to-back issue, reset abort, exponent sweep).
//  Revision : 1.0  initial release
// ============================================================================
module tb_fmul;
    localparam int NSTAGE = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic [31:0] x1, x2;
    logic [31:0] y;
    logic        done, busy;
`ifdef FMUL_FLAGS_EN
    logic [2:0]  flags;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fmul #(.NSTAGE(NSTAGE)) dut (
        .clk  (clk),
        .rstn (rstn),
        .en   (en),
        .x1   (x1),
        .x2   (x2),
        .y    (y),
        .done (done),
        .busy (busy)
`ifdef FMUL_FLAGS_EN
        ,
        .flags(flags)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // issue one op and wait (bounded) for its done pulse
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output int lat);
        x1 = a; x2 = b; en = 1'b1;
        tick();
        en  = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < NSTAGE + 8) begin
            tick();
            lat++;
        end
        r = y;
    endtask

    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_y, input logic [2:0] exp_fl);
        logic [31:0] r;
        int          lat;
        run_op(a, b, r, lat);
        chk({tag, "_lat"}, lat, NSTAGE);
        chk({tag, "_y"}, r, exp_y);
`ifdef FMUL_FLAGS_EN
        chk({tag, "_flags"}, {29'd0, flags}, {29'd0, exp_fl});
`else
        if (exp_fl == 3'b111) $display("note: unreachable flag pattern");
`endif
    endtask

    function automatic real to_real(input logic [31:0] a);
        logic [10:0] de;
        de = 11'(int'(a[30:23]) - 127 + 1023);
        return $bitstoreal({a[31], de, a[22:0], 29'd0});
    endfunction

    // reference: exact double product, truncated to single (within 1 ulp of RNE)
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] ev, output bit skip);
        logic        sg, za, zb, ia, ib, na, nb;
        real         p;
        logic [63:0] d;
        int          ue;
        sg = a[31] ^ b[31];
        za = (a[30:23] == 8'd0);
        zb = (b[30:23] == 8'd0);
        ia = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        ib = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        na = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        skip = 1'b0;
        ev   = 32'd0;
        if (na || nb || (ia && zb) || (ib && za)) ev = 32'h7FC00000;
        else if (ia || ib)                        ev = {sg, 8'hFF, 23'd0};
        else if (za || zb)                        ev = {sg, 31'd0};
        else begin
            p  = to_real(a) * to_real(b);
            d  = $realtobits(p);
            ue = int'(d[62:52]) - 1023;
            if (ue > 127)        ev = {sg, 8'hFF, 23'd0};
            else if (ue < -127)  ev = {sg, 31'd0};
            else if (ue == -127) skip = 1'b1;
            else                 ev = {d[63], 8'(ue + 127), d[51:29]};
        end
    endfunction

    logic [31:0] ops_a [4];
    logic [31:0] ops_b [4];
    logic [31:0] ops_y [4];
    logic [22:0] mants [5];
    logic [31:0] bsel  [2];

    initial begin
        logic [31:0] r, ev, a, b;
        int          lat, ndone, dd;
        bit          skip, ok;

        rstn = 1'b1; en = 1'b0; x1 = '0; x2 = '0;
        tick(); tick();
        chk("rst_y", y, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rstn = 1'b0;
        tick();

        // T1..T4 directed
        directed("t1_mul",     32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000);
        directed("t2_ovf",     32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 3'b010);
        directed("t3_unf",     32'h00800000, 32'h3F000000, 32'h00000000, 3'b001);
        directed("t3_denorm",  32'h80000001, 32'h3F800000, 32'h80000000, 3'b000);
        directed("t4_infzero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100);
        directed("t4_neginf",  32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000);
        directed("neg_round",  32'hBF800001, 32'h3F800001, 32'hBF800002, 3'b000);
        directed("qnan_in",    32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b000);
        directed("snan_in",    32'h7F800001, 32'h3F800000, 32'h7FC00000, 3'b100);

        // T5 back-to-back
        ops_a[0] = 32'h3F800000; ops_b[0] = 32'h3F800000; ops_y[0] = 32'h3F800000;
        ops_a[1] = 32'h40000000; ops_b[1] = 32'h40400000; ops_y[1] = 32'h40C00000;
        ops_a[2] = 32'hBFC00000; ops_b[2] = 32'h40000000; ops_y[2] = 32'hC0400000;
        ops_a[3] = 32'h3F800001; ops_b[3] = 32'h3F800001; ops_y[3] = 32'h3F800002;
        for (int k = 0; k < NSTAGE + 4; k++) begin
            if (k < 4) begin
                en = 1'b1; x1 = ops_a[k]; x2 = ops_b[k];
            end else begin
                en = 1'b0;
            end
            tick();
            if (k + 1 >= NSTAGE && k + 1 - NSTAGE < 4) begin
                chk($sformatf("t5_done%0d", k + 1 - NSTAGE), {31'd0, done}, 32'd1);
                chk($sformatf("t5_y%0d", k + 1 - NSTAGE), y, ops_y[k + 1 - NSTAGE]);
            end
            if (k + 1 <= NSTAGE + 3)
                chk($sformatf("t5_busy%0d", k + 1), {31'd0, busy}, 32'd1);
        end
        chk("t5_busy_end", {31'd0, busy}, 32'd0);
        chk("t5_done_end", {31'd0, done}, 32'd0);
        chk("t5_y_hold", y, 32'h3F800002);

        // T6 reset with two ops in flight
        en = 1'b1; x1 = 32'h40000000; x2 = 32'h40000000;
        tick();
        x1 = 32'h40400000; x2 = 32'h40400000;
        tick();
        en = 1'b0;
        chk("t6_busy_pre", {31'd0, busy}, 32'd1);
        rstn = 1'b1;
        #1;
        chk("t6_y_rst", y, 32'd0);
        chk("t6_done_rst", {31'd0, done}, 32'd0);
        chk("t6_busy_rst", {31'd0, busy}, 32'd0);
        tick();
        rstn = 1'b0;
        ndone = 0;
        for (int k = 0; k < NSTAGE + 3; k++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        chk("t6_no_done", ndone, 0);
        chk("t6_busy_after", {31'd0, busy}, 32'd0);
        directed("t6_fresh", 32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000);

        // exponent sweep against a real-arithmetic reference
        mants[0] = 23'h000000; mants[1] = 23'h000001; mants[2] = 23'h000002;
        mants[3] = 23'h7FFFFF; mants[4] = 23'h400000;
        bsel[0]  = 32'h3FC00001; bsel[1] = 32'hC0490FDB;
        for (int e = 0; e < 256; e++) begin
            for (int s = 0; s < 2; s++) begin
                for (int mi = 0; mi < 5; mi++) begin
                    for (int bi = 0; bi < 2; bi++) begin
                        a = {s[0], e[7:0], mants[mi]};
                        b = bsel[bi];
                        model(a, b, ev, skip);
                        if (!skip) begin
                            run_op(a, b, r, lat);
                            if (ev == 32'h7FC00000) begin
                                ok = (r === ev);
                            end else begin
                                dd = int'(r[30:0]) - int'(ev[30:0]);
                                ok = (r[31] === ev[31]) && (dd >= -1) && (dd <= 1);
                            end
                            ok = ok && (lat == NSTAGE);
                            checks++;
                            assert (ok === 1'b1) else begin
                                errors++;
                                $error("FAIL sweep a=%08h b=%08h observed=%08h expected=%08h (+/-1) lat=%0d",
                                       a, b, r, ev, lat);
                            end
                        end
                    end
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
